enemy_row_ctrl: RTL and testbench
=================================

Name: enemy_row_ctrl

Overview:
- Parametrised successor to the fixed seven-enemy draw-enable.
- Owns the whole enemy row: formation offset, sweep/drop state machine, per-enemy alive mask, bullet-hit detection and registered pixel enable.
- Sits between the VGA sync counters, the bullet module and the pixel mux.
- Replaces the externally supplied posX/posY with internally generated, frame-stepped motion.

Parameters:
N_ENEMY, 7, number of enemies in the row (1..16)
BASE_X, 31, centre X of enemy 0 at zero offset
BASE_Y, 239, centre Y of the row at zero offset
PITCH, 24, X spacing between adjacent enemy centres
HALF, 8, half-size of the square hit/draw box (box is 2*HALF+1 pixels)
STEP_X, 2, horizontal offset change per frame tick
STEP_Y, 8, vertical offset change per drop
MAX_OFFX, 400, maximum horizontal offset (minimum is 0)
MAX_OFFY, 160, maximum vertical offset

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
frame_tick  in  1  one-cycle pulse per video frame
restart  in  1  one-cycle pulse: revive all enemies and return to origin
horCnt  in  10  current pixel X
verCnt  in  10  current pixel Y
bullet_valid  in  1  bullet position valid this cycle
bullet_x  in  10  bullet X
bullet_y  in  10  bullet Y
enable  out  1  registered: current pixel lies inside an alive enemy box
enemy_idx  out  4  registered index of the enemy being drawn (0 when enable=0)
alive  out  N_ENEMY  alive mask, bit i = enemy i
posX  out  10  current horizontal formation offset
posY  out  10  current vertical formation offset
hit_pulse  out  1  one-cycle pulse on each kill
all_dead  out  1  combinational, alive==0
reached_bottom  out  1  sticky: posY reached MAX_OFFY

Behaviour:
- Reset (async, immediate): alive=all ones; posX=0; posY=0; state=MOVE_R; enable=0; enemy_idx=0; hit_pulse=0; reached_bottom=0.
- Enemy i centre: cx_i = BASE_X + i*PITCH + posX; cy = BASE_Y + posY.
- Box test: X in [cx_i-HALF, cx_i+HALF], Y in [cy-HALF, cy+HALF], inclusive.
- All box arithmetic is 11-bit. Lower bounds are tested as coord+HALF >= centre, so no underflow occurs.
- Draw: enable is asserted at the clock edge after horCnt/verCnt present a pixel inside the box of any alive enemy (1-cycle latency).
- enemy_idx is the lowest matching index. Dead enemies never draw.
- Movement FSM, advancing only on frame_tick:
  - MOVE_R: if posX+STEP_X > MAX_OFFX, go to DROP_L; otherwise posX += STEP_X.
  - DROP_L: posY = min(posY+STEP_Y, MAX_OFFY); go to MOVE_L.
  - MOVE_L: if posX < STEP_X, go to DROP_R; otherwise posX -= STEP_X.
  - DROP_R: same as DROP_L; go to MOVE_R.
  - A transition tick does not move in X, so each reversal spends one tick on the move-state exit and one on the drop.
- reached_bottom sets when a drop leaves posY==MAX_OFFY. It is cleared only by rst or restart.
- Movement freezes (the FSM holds) while all_dead=1.
- Hit: on a clock with bullet_valid=1, the bullet is box-tested against alive enemies using the pre-update posX/posY.
  - On a match, the lowest matching index is cleared and hit_pulse=1 for exactly one cycle.
  - At most one kill per cycle.
- Simultaneous frame_tick and hit: both take effect in the same cycle. The hit uses the old offsets.
- restart: synchronous; same values as reset. It takes priority over frame_tick and hit in the same cycle.
- posX/posY never leave [0,MAX_OFFX]/[0,MAX_OFFY].
- Reset asserted mid-frame: outputs return to reset values immediately. enable stays 0 until the first post-reset edge.

Test Plan:
- Draw latency, after reset: drive horCnt=31, verCnt=239 → enable=1, enemy_idx=0 one cycle later. Then horCnt=40 (gap pixel) → enable=0. Then horCnt=47 → enable=1, idx=1.
- Box edges: horCnt=23/39, verCnt=231/247 → enable=1. horCnt=22/40 or verCnt=230/248 → enable=0.
- Hit: bullet_valid=1 at (79,245) → hit_pulse for 1 cycle, alive=7'b1111011. Later pixel (79,239) → enable=0. Second bullet at the same spot → no pulse.
- Sweep: 200 frame_ticks → posX=400. Next tick → DROP_L (posX=400, posY=0). Next → posY=8, MOVE_L. Next → posX=398.
- Bottom clamp: run until posY=160 → reached_bottom=1. A further drop leaves posY=160. Then restart → posX=posY=0, alive all ones, reached_bottom=0.
- Simultaneous events: frame_tick plus a bullet at old enemy-0 centre in the same cycle → kill registered and posX advances by 2. Kill all seven → all_dead=1 and posX frozen across 10 ticks.

Source files
------------

// File: rtl/enemy_row_ctrl_if.sv
// Signal bundle between the enemy row controller, the VGA counters,
// the bullet module and the pixel mux.
interface enemy_row_ctrl_if #(
    parameter int N_ENEMY = 7
);
    logic               frame_tick;
    logic               restart;
    logic [9:0]         horCnt;
    logic [9:0]         verCnt;
    logic               bullet_valid;
    logic [9:0]         bullet_x;
    logic [9:0]         bullet_y;
    logic               enable;
    logic [3:0]         enemy_idx;
    logic [N_ENEMY-1:0] alive;
    logic [9:0]         posX;
    logic [9:0]         posY;
    logic               hit_pulse;
    logic               all_dead;
    logic               reached_bottom;

    modport master (
        output frame_tick, restart, horCnt, verCnt, bullet_valid, bullet_x, bullet_y,
        input  enable, enemy_idx, alive, posX, posY, hit_pulse, all_dead, reached_bottom
    );

    modport slave (
        input  frame_tick, restart, horCnt, verCnt, bullet_valid, bullet_x, bullet_y,
        output enable, enemy_idx, alive, posX, posY, hit_pulse, all_dead, reached_bottom
    );
endinterface

// File: rtl/enemy_row_ctrl.sv
// Enemy row controller: formation sweep/drop motion, alive mask, bullet kills
// and a registered draw enable for the pixel under the VGA counters.
module enemy_row_ctrl #(
    parameter int N_ENEMY  = 7,
    parameter int BASE_X   = 31,
    parameter int BASE_Y   = 239,
    parameter int PITCH    = 24,
    parameter int HALF     = 8,
    parameter int STEP_X   = 2,
    parameter int STEP_Y   = 8,
    parameter int MAX_OFFX = 400,
    parameter int MAX_OFFY = 160
) (
    input  logic             clk,
    input  logic             rst,
    enemy_row_ctrl_if.slave  bus
);

    localparam logic [10:0] HALF_W     = 11'(HALF);
    localparam logic [10:0] STEP_X_W   = 11'(STEP_X);
    localparam logic [10:0] STEP_Y_W   = 11'(STEP_Y);
    localparam logic [10:0] MAX_OFFX_W = 11'(MAX_OFFX);
    localparam logic [10:0] MAX_OFFY_W = 11'(MAX_OFFY);
    localparam logic [9:0]  STEP_X_P   = 10'(STEP_X);
    localparam logic [9:0]  MAX_OFFY_P = 10'(MAX_OFFY);
    localparam logic [N_ENEMY-1:0] ALL_ALIVE = {N_ENEMY{1'b1}};
    localparam logic [N_ENEMY-1:0] NONE      = {N_ENEMY{1'b0}};
    localparam logic [N_ENEMY-1:0] ONE       = N_ENEMY'(1'b1);

    typedef enum logic [1:0] {
        MOVE_R = 2'd0,
        DROP_L = 2'd1,
        MOVE_L = 2'd2,
        DROP_R = 2'd3
    } state_t;

    state_t             state_r;
    state_t             nextState_s;
    logic [9:0]         posX_r;
    logic [9:0]         posY_r;
    logic [9:0]         nextPosX_s;
    logic [9:0]         nextPosY_s;
    logic [10:0]        dropSum_s;
    logic               setBottom_s;
    logic [N_ENEMY-1:0] alive_r;
    logic [N_ENEMY-1:0] drawMatch_s;
    logic [N_ENEMY-1:0] shotMatch_s;
    logic [N_ENEMY-1:0] shotOne_s;
    logic               drawHit_s;
    logic [3:0]         drawIdx_s;
    logic               shotHit_s;
    logic               allDead_s;
    logic               enable_r;
    logic [3:0]         enemyIdx_r;
    logic               hitPulse_r;
    logic               reachedBottom_r;

    // Lower bounds are written as coord+HALF >= centre so nothing underflows.
    function automatic logic inBox(input logic [9:0] px, input logic [9:0] py,
                                   input int idx, input logic [9:0] offX,
                                   input logic [9:0] offY);
        logic [10:0] cx;
        logic [10:0] cy;
        logic [10:0] x;
        logic [10:0] y;
        cx = 11'(BASE_X + idx * PITCH) + {1'b0, offX};
        cy = 11'(BASE_Y) + {1'b0, offY};
        x  = {1'b0, px};
        y  = {1'b0, py};
        return (x + HALF_W >= cx) && (x <= cx + HALF_W) &&
               (y + HALF_W >= cy) && (y <= cy + HALF_W);
    endfunction

    function automatic logic [3:0] lowestSet(input logic [N_ENEMY-1:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = N_ENEMY - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    assign allDead_s = (alive_r == NONE);

    // Per-enemy box matches for the current pixel and the bullet, old offsets.
    always_comb begin
        drawMatch_s = NONE;
        shotMatch_s = NONE;
        for (int i = 0; i < N_ENEMY; i++) begin
            drawMatch_s[i] = alive_r[i] &
                             inBox(bus.horCnt, bus.verCnt, i, posX_r, posY_r);
            shotMatch_s[i] = bus.bullet_valid & alive_r[i] &
                             inBox(bus.bullet_x, bus.bullet_y, i, posX_r, posY_r);
        end
    end

    // Lowest-index priority: isolate the least significant matching bit.
    always_comb begin
        drawHit_s = (drawMatch_s != NONE);
        drawIdx_s = lowestSet(drawMatch_s);
        shotHit_s = (shotMatch_s != NONE);
        shotOne_s = shotMatch_s & (~shotMatch_s + ONE);
    end

    // Movement next-state: one step per frame tick, frozen once the row is empty.
    always_comb begin
        nextState_s = state_r;
        nextPosX_s  = posX_r;
        nextPosY_s  = posY_r;
        setBottom_s = 1'b0;
        dropSum_s   = {1'b0, posY_r} + STEP_Y_W;
        if (bus.frame_tick && !allDead_s) begin
            case (state_r)
                MOVE_R: begin
                    if (({1'b0, posX_r} + STEP_X_W) > MAX_OFFX_W) begin
                        nextState_s = DROP_L;
                    end else begin
                        nextPosX_s = posX_r + STEP_X_P;
                    end
                end
                MOVE_L: begin
                    if (posX_r < STEP_X_P) begin
                        nextState_s = DROP_R;
                    end else begin
                        nextPosX_s = posX_r - STEP_X_P;
                    end
                end
                DROP_L, DROP_R: begin
                    if (dropSum_s >= MAX_OFFY_W) begin
                        nextPosY_s  = MAX_OFFY_P;
                        setBottom_s = 1'b1;
                    end else begin
                        nextPosY_s  = dropSum_s[9:0];
                    end
                    nextState_s = (state_r == DROP_L) ? MOVE_L : MOVE_R;
                end
                default: begin
                    nextState_s = MOVE_R;
                end
            endcase
        end else begin
            nextState_s = state_r;
        end
    end

    // Formation state register; restart returns to origin like reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= MOVE_R;
            posX_r  <= 10'd0;
            posY_r  <= 10'd0;
        end else if (bus.restart) begin
            state_r <= MOVE_R;
            posX_r  <= 10'd0;
            posY_r  <= 10'd0;
        end else begin
            state_r <= nextState_s;
            posX_r  <= nextPosX_s;
            posY_r  <= nextPosY_s;
        end
    end

    // Alive mask, kill pulse, bottom flag and registered draw outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alive_r         <= ALL_ALIVE;
            hitPulse_r      <= 1'b0;
            reachedBottom_r <= 1'b0;
            enable_r        <= 1'b0;
            enemyIdx_r      <= 4'd0;
        end else if (bus.restart) begin
            alive_r         <= ALL_ALIVE;
            hitPulse_r      <= 1'b0;
            reachedBottom_r <= 1'b0;
            enable_r        <= 1'b0;
            enemyIdx_r      <= 4'd0;
        end else begin
            alive_r         <= alive_r & ~shotOne_s;
            hitPulse_r      <= shotHit_s;
            reachedBottom_r <= reachedBottom_r | setBottom_s;
            enable_r        <= drawHit_s;
            enemyIdx_r      <= drawIdx_s;
        end
    end

    assign bus.enable         = enable_r;
    assign bus.enemy_idx      = enemyIdx_r;
    assign bus.alive          = alive_r;
    assign bus.posX           = posX_r;
    assign bus.posY           = posY_r;
    assign bus.hit_pulse      = hitPulse_r;
    assign bus.all_dead       = allDead_s;
    assign bus.reached_bottom = reachedBottom_r;

endmodule

// File: tb/tb_enemy_row_ctrl.sv
// Directed plus randomized bench for enemy_row_ctrl against a behavioural row model.
module tb_enemy_row_ctrl;
    localparam int N = 7;

    logic clk = 1'b0;
    logic rst;
    enemy_row_ctrl_if #(.N_ENEMY(N)) bus ();
    enemy_row_ctrl #(.N_ENEMY(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: offsets, sweep direction and a pending-drop flag.
    int          mX, mY, mDir, mIdx;
    bit          mDropNext, mBottom, mEn, mHit;
    bit [N-1:0]  mAlive;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int centreX(input int i);
        return 31 + 24 * i + mX;
    endfunction

    function automatic int absv(input int d);
        return (d < 0) ? -d : d;
    endfunction

    function automatic int lowestBox(input int px, input int py);
        for (int i = 0; i < N; i++) begin
            if (mAlive[i] && absv(px - centreX(i)) <= 8 && absv(py - (239 + mY)) <= 8)
                return i;
        end
        return -1;
    endfunction

    task automatic modelReset();
        mX = 0; mY = 0; mDir = 1; mDropNext = 1'b0; mBottom = 1'b0;
        mAlive = '1; mEn = 1'b0; mIdx = 0; mHit = 1'b0;
    endtask

    task automatic moveOnce();
        if (mDropNext) begin
            mY = (mY + 8 > 160) ? 160 : mY + 8;
            if (mY == 160) mBottom = 1'b1;
            mDropNext = 1'b0;
            mDir = -mDir;
        end else if (mDir > 0) begin
            if (mX + 2 > 400) mDropNext = 1'b1; else mX += 2;
        end else begin
            if (mX < 2) mDropNext = 1'b1; else mX -= 2;
        end
    endtask

    task automatic modelEdge();
        int d, k;
        bit wasDead;
        d = lowestBox(int'(bus.horCnt), int'(bus.verCnt));
        mEn = (d >= 0);
        mIdx = mEn ? d : 0;
        if (bus.restart) begin
            modelReset();
        end else begin
            wasDead = (mAlive == '0);
            k = bus.bullet_valid ? lowestBox(int'(bus.bullet_x), int'(bus.bullet_y)) : -1;
            mHit = (k >= 0);
            if (k >= 0) mAlive[k] = 1'b0;
            if (bus.frame_tick && !wasDead) moveOnce();
        end
    endtask

    task automatic checkAll();
        check("enable",   32'(bus.enable),         32'(mEn));
        check("idx",      32'(bus.enemy_idx),      32'(mIdx));
        check("alive",    32'(bus.alive),          32'(mAlive));
        check("posX",     32'(bus.posX),           32'(mX));
        check("posY",     32'(bus.posY),           32'(mY));
        check("hit",      32'(bus.hit_pulse),      32'(mHit));
        check("allDead",  32'(bus.all_dead),       32'(mAlive == '0));
        check("bottom",   32'(bus.reached_bottom), 32'(mBottom));
    endtask

    task automatic cycle();
        modelEdge();
        @(posedge clk);
        #1;
        checkAll();
    endtask

    task automatic setPix(input int h, input int v);
        bus.horCnt = 10'(h);
        bus.verCnt = 10'(v);
    endtask

    task automatic randPixNearRow();
        int i;
        i = int'($urandom_range(0, N - 1));
        setPix(centreX(i) + int'($urandom_range(0, 24)) - 12, 239 + mY + int'($urandom_range(0, 22)) - 11);
    endtask

    int boxH[8] = '{23, 39, 31, 31, 22, 40, 31, 31};
    int boxV[8] = '{239, 239, 231, 247, 239, 239, 230, 248};
    int boxE[8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    int frozenX;

    initial begin
        rst = 1'b1;
        bus.frame_tick = 1'b0; bus.restart = 1'b0; bus.bullet_valid = 1'b0;
        bus.bullet_x = 10'd0; bus.bullet_y = 10'd0; setPix(0, 0);
        modelReset();
        #2;
        check("rstEnable", 32'(bus.enable), 32'd0);
        check("rstAlive",  32'(bus.alive),  32'h7F);
        check("rstPosX",   32'(bus.posX),   32'd0);
        check("rstPosY",   32'(bus.posY),   32'd0);
        check("rstBottom", 32'(bus.reached_bottom), 32'd0);
        @(posedge clk); #1; rst = 1'b0;

        // Draw latency and gap pixel
        setPix(31, 239); cycle();
        check("draw0En", 32'(bus.enable), 32'd1);
        check("draw0Idx", 32'(bus.enemy_idx), 32'd0);
        setPix(40, 239); cycle();
        check("gapEn", 32'(bus.enable), 32'd0);
        setPix(47, 239); cycle();
        check("draw1En", 32'(bus.enable), 32'd1);
        check("draw1Idx", 32'(bus.enemy_idx), 32'd1);

        // Box edges
        for (int b = 0; b < 8; b++) begin
            setPix(boxH[b], boxV[b]); cycle();
            check("boxEdge", 32'(bus.enable), 32'(boxE[b]));
        end

        // Bullet kill on enemy 2, then no re-kill
        bus.bullet_x = 10'd79; bus.bullet_y = 10'd245; bus.bullet_valid = 1'b1; cycle();
        check("hitPulse", 32'(bus.hit_pulse), 32'd1);
        check("hitAlive", 32'(bus.alive), 32'h7B);
        bus.bullet_valid = 1'b0; setPix(79, 239); cycle();
        check("hitOnce", 32'(bus.hit_pulse), 32'd0);
        cycle();
        check("deadNoDraw", 32'(bus.enable), 32'd0);
        bus.bullet_valid = 1'b1; cycle();
        check("noReHit", 32'(bus.hit_pulse), 32'd0);
        bus.bullet_valid = 1'b0;

        // Sweep right, reversal and first drop
        bus.frame_tick = 1'b1;
        for (int t = 0; t < 200; t++) begin randPixNearRow(); cycle(); end
        check("sweepX", 32'(bus.posX), 32'd400);
        cycle();
        check("exitX", 32'(bus.posX), 32'd400);
        check("exitY", 32'(bus.posY), 32'd0);
        cycle();
        check("dropY", 32'(bus.posY), 32'd8);
        cycle();
        check("leftX", 32'(bus.posX), 32'd398);

        // Bottom clamp and sticky flag
        for (int n = 0; n < 6000 && bus.posY !== 10'd160; n++) begin randPixNearRow(); cycle(); end
        check("bottomY", 32'(bus.posY), 32'd160);
        check("bottomFlag", 32'(bus.reached_bottom), 32'd1);
        for (int n = 0; n < 410; n++) begin randPixNearRow(); cycle(); end
        check("clampY", 32'(bus.posY), 32'd160);

        // Restart beats a tick and a hit in the same cycle
        bus.restart = 1'b1; bus.bullet_valid = 1'b1;
        bus.bullet_x = 10'(centreX(0)); bus.bullet_y = 10'(239 + mY); cycle();
        bus.restart = 1'b0;
        check("rsX", 32'(bus.posX), 32'd0);
        check("rsY", 32'(bus.posY), 32'd0);
        check("rsAlive", 32'(bus.alive), 32'h7F);
        check("rsBottom", 32'(bus.reached_bottom), 32'd0);
        check("rsHit", 32'(bus.hit_pulse), 32'd0);

        // Tick and hit together, then wipe the row
        bus.bullet_x = 10'd31; bus.bullet_y = 10'd239; cycle();
        check("simAlive", 32'(bus.alive), 32'h7E);
        check("simX", 32'(bus.posX), 32'd2);
        check("simHit", 32'(bus.hit_pulse), 32'd1);
        bus.frame_tick = 1'b0;
        for (int i = 1; i < N; i++) begin
            bus.bullet_x = 10'(31 + 24 * i + 2); bus.bullet_y = 10'd239; cycle();
        end
        bus.bullet_valid = 1'b0; cycle();
        check("allDead", 32'(bus.all_dead), 32'd1);
        frozenX = int'(bus.posX);
        bus.frame_tick = 1'b1;
        for (int t = 0; t < 10; t++) cycle();
        check("frozenX", 32'(bus.posX), 32'd2);

        // Randomized traffic
        bus.restart = 1'b1; cycle(); bus.restart = 1'b0;
        for (int t = 0; t < 600; t++) begin
            bus.frame_tick = 1'($urandom_range(0, 1));
            bus.restart = ($urandom_range(0, 63) == 0);
            bus.bullet_valid = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) begin
                bus.bullet_x = 10'($urandom); bus.bullet_y = 10'($urandom);
                setPix(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
            end else begin
                randPixNearRow();
                bus.bullet_x = bus.horCnt; bus.bullet_y = bus.verCnt;
                randPixNearRow();
            end
            cycle();
        end
        bus.restart = 1'b0; bus.bullet_valid = 1'b0; bus.frame_tick = 1'b1;

        // Asynchronous reset in mid-cycle
        for (int t = 0; t < 5; t++) begin setPix(centreX(0), 239 + mY); cycle(); end
        #3; rst = 1'b1; #1;
        modelReset();
        check("arstEnable", 32'(bus.enable), 32'd0);
        check("arstPosX", 32'(bus.posX), 32'd0);
        check("arstAlive", 32'(bus.alive), 32'h7F);
        @(posedge clk); #1;
        check("arstHold", 32'(bus.enable), 32'd0);
        rst = 1'b0; bus.frame_tick = 1'b0; setPix(31, 239); cycle();
        check("postRstDraw", 32'(bus.enable), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
